// File: rtl/ysyx_22051145_ctrl_if.sv
// Handshake bundle between the multi-cycle sequencer and the datapath/bus side.
// master = sequencer, slave = datapath / instruction bus / LSU.
interface ysyx_22051145_ctrl_if #(
   parameter int CNT_W = 64
);
   logic             if_req;
   logic             if_ready;
   logic             if_rvalid;
   logic             inst_we;
   logic             mem_op;
   logic             lsu_req;
   logic             lsu_done;
   logic             wb_en;
   logic             halt_req;
   logic             rf_we;
   logic             pc_we;
   logic [2:0]       state_o;
   logic             halted;
   logic             bus_err;
   logic [CNT_W-1:0] retired;

   modport master (
      output if_req, inst_we, lsu_req, rf_we, pc_we, state_o, halted, bus_err, retired,
      input  if_ready, if_rvalid, mem_op, lsu_done, wb_en, halt_req
   );

   modport slave (
      input  if_req, inst_we, lsu_req, rf_we, pc_we, state_o, halted, bus_err, retired,
      output if_ready, if_rvalid, mem_op, lsu_done, wb_en, halt_req
   );
endinterface

// File: rtl/ysyx_22051145_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/WAIT_I/DECODE/EXEC/MEM/WB with a bus
// watchdog, EBREAK halt and retired-instruction counter.
module ysyx_22051145_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 64
) (
   input logic                   clk,
   input logic                   rst,
   ysyx_22051145_ctrl_if.master  bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_WAIT_I = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   // Watchdog counts 0..TIMEOUT-1; reaching TIMEOUT is the expiry step itself.
   localparam int             WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t           state_q;
   logic [WD_W-1:0]  wd_q;
   logic [CNT_W-1:0] retired_q;
   logic             halted_q;
   logic             bus_err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         wd_q      <= '0;
         retired_q <= '0;
         halted_q  <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (bus.if_ready) begin
                  state_q <= bus.if_rvalid ? S_DECODE : S_WAIT_I;
                  wd_q    <= '0;
               end
            end
            S_WAIT_I: begin
               if (bus.if_rvalid) begin
                  state_q <= S_DECODE;
               end else if (wd_q == WD_LAST) begin
                  state_q   <= S_ERROR;
                  bus_err_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            S_DECODE: state_q <= S_EXEC;
            S_EXEC: begin
               if (bus.mem_op) begin
                  state_q <= S_MEM;
                  wd_q    <= '0;
               end else begin
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (bus.lsu_done) begin
                  state_q <= S_WB;
               end else if (wd_q == WD_LAST) begin
                  state_q   <= S_ERROR;
                  bus_err_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            S_WB: begin
               retired_q <= retired_q + CNT_W'(1);
               if (bus.halt_req) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= S_FETCH;
               end
            end
            S_HALT, S_ERROR: ;
         endcase
      end
   end

   // Strobes react to same-cycle handshakes, so they are decoded from the state;
   // gating with rst keeps a reset cycle from firing anything.
   assign bus.if_req  = rst && (state_q == S_FETCH);
   assign bus.inst_we = rst && (((state_q == S_FETCH) && bus.if_ready && bus.if_rvalid) ||
                                ((state_q == S_WAIT_I) && bus.if_rvalid));
   assign bus.lsu_req = rst && (state_q == S_MEM);
   assign bus.rf_we   = rst && (state_q == S_WB) && bus.wb_en;
   assign bus.pc_we   = rst && (state_q == S_WB);
   assign bus.state_o = state_q;
   assign bus.halted  = halted_q;
   assign bus.bus_err = bus_err_q;
   assign bus.retired = retired_q;
endmodule
